output_accum_buffer: RTL and testbench
======================================

# output_accum_buffer

Parametrised output-side collector for the systolic array: one instance per array column. Shifts in DEPTH partial sums per K-tile over a valid/ready handshake, accumulates them across K-tiles into a per-row accumulator bank, then drains the finished rows in order over a valid/ready output with a last marker. It replaces the fixed-size, handshake-less output shifter with explicit tile first/last control and back-pressure on both sides.

## Interface
- DATA_W, default 32: width of each partial sum and accumulator (two's complement).
- DEPTH, default 8: rows per tile (array height); DEPTH >= 1.
- CNT_W, derived: $clog2(DEPTH)+1. Local, not overridable.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; one clock, synchronous, active-high.
- in_valid  in  1  partial-sum beat present.
- in_data  in  DATA_W  partial sum; beat k of a tile is row k.
- in_first  in  1  tile is the first K-tile: overwrite the accumulators instead of adding. Sampled on beat 0 only.
- in_last  in  1  tile is the last K-tile: drain after accumulating. Sampled on beat 0 only.
- in_ready  out  1  high only in LOAD.
- out_valid  out  1  drained row present.
- out_data  out  DATA_W  accumulator row.
- out_last  out  1  high with row DEPTH-1.
- out_ready  in  1  consumer accepts the row.
- sat_flag  out  1  sticky saturation indicator (see Configuration).
- busy  out  1  high when in ACC or DRAIN, or when any LOAD beat has been taken.

## Operation
- Storage:
  - shift bank mem[0..DEPTH-1];
  - accumulator bank acc[0..DEPTH-1];
  - beat counter cnt (CNT_W bits);
  - latched first_q and last_q.
- LOAD:
  - Handshake is in_valid && in_ready.
  - On each handshake, mem shifts toward index 0, in_data enters mem[DEPTH-1], and cnt increments.
  - On beat 0 (cnt==0), first_q <= in_first and last_q <= in_last.
  - After DEPTH beats, mem[k] holds beat k. Go to ACC and set cnt to 0.
- ACC (exactly one cycle):
  - For all i: acc[i] <= first_q ? mem[i] : acc[i] + mem[i].
  - Next state is DRAIN if last_q, else LOAD.
- DRAIN:
  - out_data = acc[cnt] and out_valid = 1.
  - Each output handshake increments cnt.
  - On the handshake with cnt==DEPTH-1: all acc <= 0, sat_flag <= 0, cnt <= 0, state LOAD.
- A non-first tile after a drain adds to zeros, so the result equals overwrite.
- in_valid while in_ready=0 has no effect. out_data, out_valid and out_last hold stable while out_ready=0.
- Reset (including mid-tile or mid-drain):
  - state LOAD, cnt 0, mem 0, acc 0, first_q and last_q 0;
  - in_ready 1, out_valid 0, out_data 0, out_last 0, sat_flag 0, busy 0;
  - the partial tile is discarded.

## Timing
- in_ready is a function of registered state only; there is no combinational path from in_valid or out_ready to any output.
- One beat can be accepted per cycle; a tile takes DEPTH cycles minimum.
- Final-beat handshake at edge E:
  - ACC occupies the cycle after E;
  - accumulators update at E+1;
  - out_valid=1 from E+1, so row 0 is presented 2 edges after the final beat.
- With out_ready held at 1, the drain takes DEPTH cycles. in_ready returns to 1 the cycle after the last output handshake.
- Non-last tiles: in_ready is low for exactly 1 cycle (ACC) between tiles.
- Back-to-back best case per tile is DEPTH+1 cycles, plus DEPTH for the final drain.

## Configuration
- OUTPUT_ACC_SATURATE_EN defined:
  - ACC add is signed-saturating: results clamp to 2^(DATA_W-1)-1 or -2^(DATA_W-1).
  - Any clamp sets sat_flag, which stays set until drain completion or reset.
- Not defined:
  - The add wraps modulo 2^DATA_W.
  - sat_flag is tied to 0.

## Test plan
- DATA_W=16, DEPTH=4. Tile {1,2,3,4} with first=1, last=1 -> out 1,2,3,4; out_last only on 4; out_valid 2 edges after beat 4.
- Three tiles {1,2,3,4}, {10,20,30,40}, {100,100,100,100}, first only on tile 1 and last only on tile 3 -> out 111,122,133,144; in_ready low 1 cycle between tiles.
- Drain with out_ready toggling 1,0,0,1,... -> each row held stable while stalled; all 4 rows delivered exactly once; in_valid during drain ignored.
- Tiles {0x7FF0,...} then {0x0020,...} with first/last on tiles 1/2:
  - with the macro, out 0x7FFF and sat_flag=1 until the drain ends;
  - without it, out 0x8010 and sat_flag=0.
- rst asserted after 2 beats of a tile, and again mid-drain -> next cycle in_ready=1, out_valid=0, busy=0; a following tile {5,6,7,8} with first=0, last=1 yields 5,6,7,8.
- DEPTH=1 build: single beat 9 with first=1, last=1 -> out 9 with out_last=1.

Source files
------------

// File: rtl/output_accum_buffer.sv
// Column output collector: shifts in DEPTH partial sums per K-tile, accumulates
// across K-tiles, then drains rows with a last marker. Optional OUTPUT_ACC_SATURATE_EN.
//
// state   | meaning
// S_LOAD  | accepting partial-sum beats into the shift bank
// S_ACC   | one cycle: fold shift bank into accumulator bank
// S_DRAIN | presenting accumulator rows on the output handshake
module output_accum_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_first,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              sat_flag,
    output logic              busy
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(DEPTH - 1);

    typedef enum logic [1:0] {S_LOAD, S_ACC, S_DRAIN} state_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] acc [DEPTH];
    logic [DATA_W-1:0] sum_next [DEPTH];
    logic              first_q, last_q;
    logic              load_hs, out_hs;

    always_comb begin
        state_d = state;
        load_hs = (state == S_LOAD) && in_valid;
        out_hs  = (state == S_DRAIN) && out_ready;
        case (state)
            S_LOAD:  if (load_hs && cnt == CNT_END) state_d = S_ACC;
            S_ACC:   state_d = last_q ? S_DRAIN : S_LOAD;
            S_DRAIN: if (out_hs && cnt == CNT_END) state_d = S_LOAD;
            default: state_d = S_LOAD;
        endcase
    end

`ifdef OUTPUT_ACC_SATURATE_EN
    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    logic [DATA_W:0] ext;
    logic            clamp_any;
    logic            sat_q;

    // Sign-extended add: the two top bits disagree exactly on overflow.
    always_comb begin
        clamp_any = 1'b0;
        ext       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ext = {acc[i][DATA_W-1], acc[i]} + {mem[i][DATA_W-1], mem[i]};
            if (ext[DATA_W] != ext[DATA_W-1]) begin
                sum_next[i] = ext[DATA_W] ? SAT_MIN : SAT_MAX;
                clamp_any   = 1'b1;
            end else begin
                sum_next[i] = ext[DATA_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            sat_q <= 1'b0;
        else if (out_hs && cnt == CNT_END)
            sat_q <= 1'b0;
        else if (state == S_ACC && !first_q && clamp_any)
            sat_q <= 1'b1;
    end

    assign sat_flag = sat_q;
`else
    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            sum_next[i] = acc[i] + mem[i];
    end

    assign sat_flag = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_LOAD;
            cnt     <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
                acc[i] <= '0;
            end
        end else begin
            state <= state_d;
            if (load_hs) begin
                for (int i = 0; i < DEPTH - 1; i++)
                    mem[i] <= mem[i+1];
                mem[DEPTH-1] <= in_data;
                cnt <= (cnt == CNT_END) ? '0 : cnt + CNT_W'(1);
                if (cnt == '0) begin
                    first_q <= in_first;
                    last_q  <= in_last;
                end
            end
            if (state == S_ACC) begin
                for (int i = 0; i < DEPTH; i++)
                    acc[i] <= first_q ? mem[i] : sum_next[i];
            end
            if (out_hs) begin
                if (cnt == CNT_END) begin
                    cnt <= '0;
                    // Clearing makes a following non-first tile behave as overwrite.
                    for (int i = 0; i < DEPTH; i++)
                        acc[i] <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        out_data = '0;
        if (state == S_DRAIN) begin
            for (int i = 0; i < DEPTH; i++)
                if (cnt == CNT_W'(i)) out_data = acc[i];
        end
    end

    assign in_ready  = (state == S_LOAD);
    assign out_valid = (state == S_DRAIN);
    assign out_last  = (state == S_DRAIN) && (cnt == CNT_END);
    assign busy      = (state != S_LOAD) || (cnt != '0);

endmodule

// File: tb/tb_output_accum_buffer.sv
// Scoreboard bench for output_accum_buffer (DEPTH=4 main instance, DEPTH=1 side instance);
// expected rows come from an integer accumulate/clamp model of whole tiles.
module tb_output_accum_buffer;
    localparam int W = 16;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic [W-1:0] in_data = '0;
    logic         in_ready, out_valid, out_last, sat_flag, busy;
    logic [W-1:0] out_data;

    logic         d1_in_valid = 1'b0, d1_out_ready = 1'b1;
    logic [W-1:0] d1_in_data = '0;
    logic         d1_in_ready, d1_out_valid, d1_out_last, d1_sat_flag, d1_busy;
    logic [W-1:0] d1_out_data;

    always #5 clk = ~clk;

    output_accum_buffer #(.DATA_W(W), .DEPTH(D)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_first(in_first), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .sat_flag(sat_flag), .busy(busy));

    output_accum_buffer #(.DATA_W(W), .DEPTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(d1_in_valid), .in_data(d1_in_data),
        .in_first(1'b1), .in_last(1'b1), .in_ready(d1_in_ready),
        .out_valid(d1_out_valid), .out_data(d1_out_data), .out_last(d1_out_last),
        .out_ready(d1_out_ready), .sat_flag(d1_sat_flag), .busy(d1_busy));

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
        logic         sat;
    } exp_t;

    exp_t exp_q[$];
    int   acc_m [D];
    bit   sat_m;
    int   checks = 0;
    int   errors = 0;
    int   rdy_mode = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: whole-tile integer arithmetic, then wrap or clamp to W bits.
    function automatic int ref_add(input int a, input int b, inout bit sat);
        int s;
        s = a + b;
`ifdef OUTPUT_ACC_SATURATE_EN
        if (s > 32767) begin s = 32767; sat = 1'b1; end
        if (s < -32768) begin s = -32768; sat = 1'b1; end
`else
        s = s & 16'hFFFF;
        if (s > 32767) s = s - 65536;
`endif
        return s;
    endfunction

    function automatic void model_tile(input logic [W-1:0] d [D], input bit first, input bit last);
        for (int i = 0; i < D; i++) begin
            if (first) acc_m[i] = int'($signed(d[i]));
            else       acc_m[i] = ref_add(acc_m[i], int'($signed(d[i])), sat_m);
        end
        if (last) begin
            for (int i = 0; i < D; i++) begin
                exp_t e;
                e.data = acc_m[i][W-1:0];
                e.last = (i == D - 1);
                e.sat  = sat_m;
                exp_q.push_back(e);
            end
            for (int i = 0; i < D; i++) acc_m[i] = 0;
            sat_m = 1'b0;
        end
    endfunction

    // Monitor: consumes rows on handshake, checks stability while stalled.
    logic         stall_prev = 1'b0;
    logic [W-1:0] stall_data;
    logic         stall_last;
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", {31'd0, out_valid}, 32'd1);
                check("stall_data", {16'd0, out_data}, {16'd0, stall_data});
                check("stall_last", {31'd0, out_last}, {31'd0, stall_last});
            end
            stall_prev = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_row", {16'd0, out_data}, 32'hDEAD);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("out_data", {16'd0, out_data}, {16'd0, e.data});
                        check("out_last", {31'd0, out_last}, {31'd0, e.last});
                        check("sat_flag", {31'd0, sat_flag}, {31'd0, e.sat});
                    end
                end else begin
                    stall_prev = 1'b1;
                    stall_data = out_data;
                    stall_last = out_last;
                end
            end
        end
    end

    int pat = 0;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: begin out_ready = (pat == 0); pat = (pat + 1) % 3; end
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic send_tile(input logic [W-1:0] d [D], input bit first, input bit last, input bit gaps);
        for (int k = 0; k < D; k++) begin
            int t;
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                cyc();
            end
            in_valid = 1'b1;
            in_data  = d[k];
            in_first = (k == 0) ? first : 1'($urandom_range(0, 1));
            in_last  = (k == 0) ? last  : 1'($urandom_range(0, 1));
            t = 0;
            while (!in_ready && t < 300) begin cyc(); t++; end
            if (t >= 300) check("in_ready_timeout", 32'd0, 32'd1);
            cyc();
        end
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        model_tile(d, first, last);
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_q.size() != 0 || busy) && t < 500) begin cyc(); t++; end
        check("drain_timeout", {31'd0, (t >= 500)}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        cyc();
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < D; i++) acc_m[i] = 0;
        sat_m = 1'b0;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {16'd0, out_data}, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        check("rst_sat_flag", {31'd0, sat_flag}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
    endtask

    logic [W-1:0] tile [D];

    initial begin
        for (int i = 0; i < D; i++) acc_m[i] = 0;
        sat_m = 1'b0;
        cyc();
        do_reset();

        // Single tile, latency of first row.
        tile = '{16'd1, 16'd2, 16'd3, 16'd4};
        send_tile(tile, 1'b1, 1'b1, 1'b0);
        check("lat_acc_valid", {31'd0, out_valid}, 32'd0);
        check("lat_acc_ready", {31'd0, in_ready}, 32'd0);
        cyc();
        check("lat_row0_valid", {31'd0, out_valid}, 32'd1);
        check("lat_row0_data", {16'd0, out_data}, 32'd1);
        wait_drain();

        // Three K-tiles accumulated; one ACC bubble between tiles.
        tile = '{16'd1, 16'd2, 16'd3, 16'd4};
        send_tile(tile, 1'b1, 1'b0, 1'b0);
        check("gap1_ready_low", {31'd0, in_ready}, 32'd0);
        cyc();
        check("gap1_ready_high", {31'd0, in_ready}, 32'd1);
        tile = '{16'd10, 16'd20, 16'd30, 16'd40};
        send_tile(tile, 1'b0, 1'b0, 1'b0);
        check("gap2_ready_low", {31'd0, in_ready}, 32'd0);
        cyc();
        check("gap2_ready_high", {31'd0, in_ready}, 32'd1);
        tile = '{16'd100, 16'd100, 16'd100, 16'd100};
        send_tile(tile, 1'b0, 1'b1, 1'b0);
        check("exp_row0_111", {16'd0, exp_q[0].data}, 32'd111);
        wait_drain();

        // Stalled drain with input beats offered and ignored.
        rdy_mode = 1;
        tile = '{16'd7, 16'd8, 16'd9, 16'd10};
        send_tile(tile, 1'b1, 1'b1, 1'b0);
        in_valid = 1'b1; in_data = 16'h5555; in_first = 1'b1; in_last = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            check("drain_busy", {31'd0, busy}, 32'd1);
        end
        in_valid = 1'b0;
        wait_drain();
        rdy_mode = 0;

        // Overflow across tiles: clamp or wrap depending on build.
        tile = '{16'h7FF0, 16'h7FF0, 16'h7FF0, 16'h7FF0};
        send_tile(tile, 1'b1, 1'b0, 1'b0);
        tile = '{16'h0020, 16'h0020, 16'h0020, 16'h0020};
        send_tile(tile, 1'b0, 1'b1, 1'b0);
`ifdef OUTPUT_ACC_SATURATE_EN
        check("sat_expected", {16'd0, exp_q[0].data}, 32'h7FFF);
`else
        check("wrap_expected", {16'd0, exp_q[0].data}, 32'h8010);
`endif
        wait_drain();
        check("sat_cleared", {31'd0, sat_flag}, 32'd0);

        // Reset mid-tile and mid-drain, then a non-first tile.
        in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1;
        in_data = 16'd50; cyc();
        in_data = 16'd51; cyc();
        in_valid = 1'b0;
        do_reset();
        rdy_mode = 1;
        tile = '{16'd21, 16'd22, 16'd23, 16'd24};
        send_tile(tile, 1'b1, 1'b1, 1'b0);
        repeat (4) cyc();
        check("mid_drain_valid", {31'd0, out_valid}, 32'd1);
        do_reset();
        rdy_mode = 0;
        tile = '{16'd5, 16'd6, 16'd7, 16'd8};
        send_tile(tile, 1'b0, 1'b1, 1'b0);
        check("exp_after_rst", {16'd0, exp_q[0].data}, 32'd5);
        wait_drain();

        // Randomized tiles with gaps and random back-pressure.
        rdy_mode = 2;
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < D; i++) tile[i] = 16'($urandom);
            send_tile(tile, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0) || (n == 29), 1'b1);
        end
        wait_drain();
        rdy_mode = 0;

        // DEPTH=1 instance.
        d1_in_valid = 1'b1; d1_in_data = 16'd9;
        check("d1_ready", {31'd0, d1_in_ready}, 32'd1);
        cyc();
        d1_in_valid = 1'b0;
        check("d1_acc_valid", {31'd0, d1_out_valid}, 32'd0);
        cyc();
        check("d1_out_valid", {31'd0, d1_out_valid}, 32'd1);
        check("d1_out_data", {16'd0, d1_out_data}, 32'd9);
        check("d1_out_last", {31'd0, d1_out_last}, 32'd1);
        cyc();
        check("d1_done_valid", {31'd0, d1_out_valid}, 32'd0);
        check("d1_done_ready", {31'd0, d1_in_ready}, 32'd1);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
